// File: rtl/shade_pixel_if.sv
// Stream interface between the surface-vector stage, the shader and the frame writer.
// The shader takes the slave modport; the upstream/downstream pair drives the master side.
interface shade_pixel_if;
  logic        valid_in;
  logic        in_ready;
  logic        hit;
  logic        obj_sel;
  logic [95:0] surfaceNormal;
  logic [95:0] surfaceLightVector;
  logic [23:0] pixel_rgb;
  logic        valid_out;
  logic        out_ready;
  logic        sof;
  logic        eol;

  modport master (
    output valid_in, hit, obj_sel, surfaceNormal, surfaceLightVector, out_ready,
    input  in_ready, pixel_rgb, valid_out, sof, eol
  );

  modport slave (
    input  valid_in, hit, obj_sel, surfaceNormal, surfaceLightVector, out_ready,
    output in_ready, pixel_rgb, valid_out, sof, eol
  );
endinterface

// File: rtl/shade_pixel.sv
// Lambert + ambient pixel shader: 4-stage pipeline (dot, intensity, colour scale, saturate/select)
// with a global stall and raster counters producing sof/eol for the frame writer.
module shade_pixel #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [31:0] AMBIENT    = 32'h00333333,
  parameter logic [23:0] OBJ0_COLOR = 24'hFF8040,
  parameter logic [23:0] OBJ1_COLOR = 24'h40C0FF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input logic         clk,
  input logic         rst,
  shade_pixel_if.slave px
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic signed [33:0] ONE_Q = 34'sh1000000;

  logic stall;
  logic advance;
  logic out_fire;

  logic               s1_valid_q;
  logic signed [33:0] s1_dot_q;
  logic signed [33:0] s1_dot_d;
  logic               s1_hit_q;
  logic               s1_obj_q;

  logic        s2_valid_q;
  logic [31:0] s2_int_q;
  logic [31:0] s2_int_d;
  logic        s2_hit_q;
  logic        s2_obj_q;

  logic        s3_valid_q;
  logic [47:0] s3_ch_q;
  logic [47:0] s3_ch_d;
  logic        s3_hit_q;

  logic        valid_out_q;
  logic [23:0] rgb_q;
  logic [23:0] rgb_d;

  logic [XW-1:0] x_q;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_d;

  assign stall       = valid_out_q && !px.out_ready;
  assign advance     = !stall;
  assign out_fire    = valid_out_q && px.out_ready;
  assign px.in_ready = advance;

  // Stage 1: per-axis Q8.24 products, each shifted back to Q8.24 before summing.
  logic signed [33:0] prod_sh [3];
  logic [2:0]         unused_prod;
  for (genvar gi = 0; gi < 3; gi++) begin : g_dot
    logic signed [63:0] n_ext;
    logic signed [63:0] l_ext;
    logic signed [63:0] prod;
    assign n_ext            = {{32{px.surfaceNormal[32*gi+31]}}, px.surfaceNormal[32*gi +: 32]};
    assign l_ext            = {{32{px.surfaceLightVector[32*gi+31]}}, px.surfaceLightVector[32*gi +: 32]};
    assign prod             = n_ext * l_ext;
    assign prod_sh[gi]      = prod[57:24];
    assign unused_prod[gi]  = ^{prod[63:58], prod[23:0]};
  end
  assign s1_dot_d = prod_sh[0] + prod_sh[1] + prod_sh[2];

  // Stage 2: clamp to [0,1.0] so non-unit inputs saturate instead of wrapping.
  logic [24:0] d_clamp;
  logic [56:0] lit_prod;
  logic        unused_lit;
  always_comb begin
    if (s1_dot_q < 0) begin
      d_clamp = '0;
    end else if (s1_dot_q > ONE_Q) begin
      d_clamp = 25'h1000000;
    end else begin
      d_clamp = s1_dot_q[24:0];
    end
  end
  assign lit_prod   = {25'd0, 32'h01000000 - AMBIENT} * {32'd0, d_clamp};
  assign s2_int_d   = AMBIENT + lit_prod[55:24];
  assign unused_lit = ^{lit_prod[56], lit_prod[23:0]};

  // Stage 3: scale base colour per channel; keep 16-bit intermediates for saturation.
  logic [23:0] base_rgb;
  logic [2:0]  unused_chan;
  assign base_rgb = s2_obj_q ? OBJ1_COLOR : OBJ0_COLOR;
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [39:0] ch_prod;
    assign ch_prod                = {32'd0, base_rgb[8*gi +: 8]} * {8'd0, s2_int_q};
    assign s3_ch_d[16*gi +: 16]   = ch_prod[39:24];
    assign unused_chan[gi]        = ^ch_prod[23:0];
  end

  // Stage 4: saturate and choose background on a miss.
  logic [23:0] sat_rgb;
  for (genvar gi = 0; gi < 3; gi++) begin : g_sat
    assign sat_rgb[8*gi +: 8] = (s3_ch_q[16*gi +: 16] > 16'd255) ? 8'hFF : s3_ch_q[16*gi +: 8];
  end
  assign rgb_d = s3_hit_q ? sat_rgb : BG_COLOR;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (out_fire) begin
      if (x_q == XW'(H_RES - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dot_q    <= '0;
      s1_hit_q    <= 1'b0;
      s1_obj_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_int_q    <= '0;
      s2_hit_q    <= 1'b0;
      s2_obj_q    <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_ch_q     <= '0;
      s3_hit_q    <= 1'b0;
      valid_out_q <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (advance) begin
        s1_valid_q  <= px.valid_in;
        s1_dot_q    <= s1_dot_d;
        s1_hit_q    <= px.hit;
        s1_obj_q    <= px.obj_sel;
        s2_valid_q  <= s1_valid_q;
        s2_int_q    <= s2_int_d;
        s2_hit_q    <= s1_hit_q;
        s2_obj_q    <= s1_obj_q;
        s3_valid_q  <= s2_valid_q;
        s3_ch_q     <= s3_ch_d;
        s3_hit_q    <= s2_hit_q;
        valid_out_q <= s3_valid_q;
        rgb_q       <= rgb_d;
      end
    end
  end

  assign px.valid_out = valid_out_q;
  assign px.pixel_rgb = rgb_q;
  assign px.sof       = valid_out_q && (x_q == '0) && (y_q == '0);
  assign px.eol       = valid_out_q && (x_q == XW'(H_RES - 1));
endmodule
